serial_adder_ctrl: RTL
======================

// Module: serial_adder_ctrl
// PURPOSE
//  Bit-serial adder controller: sequences one shared 1-bit full-adder cell over
//  WIDTH-bit operands, LSB first, one bit per clock, with a registered carry.
//  Trades WIDTH cycles of latency for a single adder cell.
//  Sits between a requester (start/done handshake) and the fa_cell datapath.
// PARAMETERS
//  WIDTH   8   operand/result width in bits; legal range 1..32
// PORTS
//  clk    in   1      rising-edge clock; the block's only clock
//  rst    in   1      synchronous, active-high reset
//  start  in   1      request; sampled only in IDLE or DONE
//  a      in   WIDTH  operand A; captured on the accepting edge
//  b      in   WIDTH  operand B; captured on the accepting edge
//  cin    in   1      carry-in; captured on the accepting edge
//  busy   out  1      1 while state==ADD
//  done   out  1      1-cycle pulse: sum/cout valid
//  sum    out  WIDTH  result; held from done until next accept
//  cout   out  1      final carry-out; held like sum
// BEHAVIOUR
//  - Clock/reset: one clock (clk); rst is synchronous, active-high.
//  - Reset: state=IDLE, busy=0, done=0, sum=0, cout=0, bit counter=0,
//    carry reg=0, operand shift regs=0.
//  - FSM states: IDLE, ADD, DONE.
//    - IDLE: start=1 -> capture a,b into shift regs, cin into carry reg,
//      clear counter -> ADD.
//    - ADD: each cycle fa_cell(a_sr[0], b_sr[0], carry) -> sum bit shifted
//      into result reg MSB side, carry reg <= cell carry, a_sr/b_sr >> 1,
//      counter++.
//      When counter==WIDTH-1 (this cycle's bit is the last) -> DONE.
//      start is ignored in ADD (no queueing, operands not re-captured).
//    - DONE: done=1 for exactly this cycle; sum<=result reg, cout<=carry reg
//      (visible this cycle).
//      start=1 in DONE -> accept as in IDLE, go to ADD (back-to-back; no idle
//      bubble). Otherwise -> IDLE.
//  - Latency: accept edge at cycle 0 -> ADD cycles 1..WIDTH -> done=1 in cycle
//    WIDTH+1. Throughput: one add per WIDTH+1 cycles.
//  - Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1); unsigned, no
//    overflow flag.
//  - sum/cout update only in DONE; stable across IDLE/ADD of a later operation
//    until its DONE.
//  - Counter width: $clog2(WIDTH), minimum 1 bit. WIDTH=1: exactly one ADD
//    cycle, done in cycle 2.
//  - Reset mid-operation (rst=1 in ADD): abort, no done pulse, all outputs to
//    reset values next edge.
//  - rst and start both high: rst wins.
//  - a/b/cin changes after acceptance have no effect on the result.
// STRUCTURE
//  - Shared package: FSM state encoding constants (S_IDLE=2'd0, S_ADD=2'd1,
//    S_DONE=2'd2). Nothing else.
//  - One sub-module: fa_cell (a, b, cin -> s, co). Purely combinational full
//    adder; s = a^b^cin, co = majority.
//  - Top-level contents: FSM, counter, shift regs, carry reg, result reg.
// TESTING
//  1. WIDTH=8: a=8'h5A, b=8'h3C, cin=0, start pulse -> busy 8 cycles; done in
//     cycle 9; sum=8'h96, cout=0.
//  2. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1 (full ripple);
//     a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
//  3. start held high through ADD with a changing -> exactly one done; result
//     uses first-captured operands; sum stable until done.
//  4. start=1 in DONE cycle, next op a=8'h01, b=8'h02 -> busy next cycle (no
//     IDLE); second done 9 cycles later with sum=8'h03.
//  5. rst=1 in cycle 4 of ADD -> next edge: busy=0, done=0, sum=0, cout=0,
//     IDLE; no done pulse follows.
//  6. WIDTH=1 build, exhaustive a,b,cin (8 cases) -> done in cycle 2;
//     {cout,sum} = a+b+cin; random 1000 ops at WIDTH=8 vs reference model.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared FSM state encoding for the bit-serial adder controller.
package serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// Combinational 1-bit full adder; the single arithmetic cell reused every cycle.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one fa_cell stepped over WIDTH bits, LSB first, with a
// registered carry. Results are held from done until the next completion.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res, res_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fs, fco;
  logic             accept, last;

  fa_cell u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .cin(carry),
    .s  (fs),
    .co (fco)
  );

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 is the LSB.
  generate
    if (WIDTH == 1) begin : g_res1
      assign res_nxt = fs;
    end else begin : g_resn
      assign res_nxt = {fs, res[WIDTH-1:1]};
    end
  endgenerate

  assign last = (cnt == LAST);
  assign busy = (state == S_ADD);
  assign done = (state == S_DONE);

  always_comb begin
    nxt    = state;
    accept = 1'b0;
    case (state)
      S_IDLE: if (start) begin nxt = S_ADD; accept = 1'b1; end
      S_ADD:  if (last) nxt = S_DONE;
      S_DONE: begin
        // Back-to-back accept straight from DONE avoids an idle bubble.
        if (start) begin nxt = S_ADD; accept = 1'b1; end
        else nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        a_sr  <= a;
        b_sr  <= b;
        carry <= cin;
        cnt   <= '0;
      end else if (state == S_ADD) begin
        a_sr  <= a_sr >> 1;
        b_sr  <= b_sr >> 1;
        carry <= fco;
        cnt   <= cnt + 1'b1;
        res   <= res_nxt;
        // Publish on the edge into DONE so outputs are valid during done.
        if (last) begin
          sum  <= res_nxt;
          cout <= fco;
        end
      end
    end
  end

endmodule
